// File: rtl/lsu_mem_master.sv
// MEM-stage load/store initiator for a doubleword-indexed data memory.
// Extends loads by lane and merges sub-doubleword stores via read-modify-write.
module lsu_mem_master #(
  parameter int ADDR_W    = 64,
  parameter int MEM_WORDS = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [63:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, LOAD, MERGE, WRITE, RESP, ERR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addrQ;
  logic [1:0]        sizeQ;
  logic              signedQ;
  logic [63:0]       wdataQ;

  logic [2:0]  alignMask;
  logic        reqBad;
  logic [5:0]  shAmt;
  logic [63:0] laneMask;
  logic [63:0] shData;
  logic [63:0] loadVal;
  logic [63:0] mergeVal;

  function automatic logic [63:0] sizeMask(input logic [1:0] sz);
    unique case (sz)
      2'd0:    sizeMask = 64'h0000_0000_0000_00FF;
      2'd1:    sizeMask = 64'h0000_0000_0000_FFFF;
      2'd2:    sizeMask = 64'h0000_0000_FFFF_FFFF;
      default: sizeMask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  always_comb begin
    alignMask = 3'd0;
    unique case (req_size)
      2'd0:    alignMask = 3'd0;
      2'd1:    alignMask = 3'd1;
      2'd2:    alignMask = 3'd3;
      default: alignMask = 3'd7;
    endcase
  end

  assign reqBad = ((req_addr[2:0] & alignMask) != 3'd0) ||
                  ({3'b0, req_addr[ADDR_W-1:3]} >= ADDR_W'(MEM_WORDS));

  assign mem_addr = {3'b0, addrQ[ADDR_W-1:3]};
  assign shAmt    = {addrQ[2:0], 3'b000};
  assign laneMask = sizeMask(sizeQ) << shAmt;
  assign shData   = mem_rdata >> shAmt;
  assign mergeVal = (mem_rdata & ~laneMask) |
                    ((wdataQ & sizeMask(sizeQ)) << shAmt);

  always_comb begin
    loadVal = shData;
    unique case (sizeQ)
      2'd0: loadVal = {{56{signedQ & shData[7]}}, shData[7:0]};
      2'd1: loadVal = {{48{signedQ & shData[15]}}, shData[15:0]};
      2'd2: loadVal = {{32{signedQ & shData[31]}}, shData[31:0]};
      default: loadVal = shData;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addrQ      <= '0;
      sizeQ      <= '0;
      signedQ    <= 1'b0;
      wdataQ     <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      unique case (state)
        IDLE: if (req_valid) begin
          addrQ     <= req_addr;
          sizeQ     <= req_size;
          signedQ   <= req_signed;
          wdataQ    <= req_wdata;
          req_ready <= 1'b0;
          if (reqBad) begin
            state      <= ERR;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else if (!req_write) begin
            state    <= LOAD;
            mem_read <= 1'b1;
          end else if (req_size == 2'd3) begin
            state     <= WRITE;
            mem_write <= 1'b1;
            mem_wdata <= req_wdata;
          end else begin
            state    <= MERGE;
            mem_read <= 1'b1;
          end
        end
        LOAD: begin
          state      <= RESP;
          mem_read   <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= loadVal;
        end
        MERGE: begin
          state     <= WRITE;
          mem_read  <= 1'b0;
          mem_write <= 1'b1;
          mem_wdata <= mergeVal;
        end
        WRITE: begin
          state      <= RESP;
          mem_write  <= 1'b0;
          mem_wdata  <= '0;
          resp_valid <= 1'b1;
        end
        RESP, ERR: begin
          state      <= IDLE;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator in the MEM stage. Accepts byte-addressed LDUR/LDURB/LDURH/LDURSW/STUR/STURB/STURH/STURW requests from the pipeline and drives the doubleword-indexed data memory port (addr, WriteData, MemRead, MemWrite, ReadData).
- Performs lane extraction with sign/zero extension on loads.
- Performs read-modify-write for sub-doubleword stores.
- Flags misaligned or out-of-range accesses. Issues no memory traffic for them.

Parameters:
- ADDR_W, 64, width of byte address and memory word index.
- MEM_WORDS, 128, number of 64-bit words in data memory; word index >= MEM_WORDS is out of range.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  core request present.
- req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready at rising edge.
- req_write  input  1  1=store, 0=load.
- req_size  input  2  0=byte, 1=half, 2=word, 3=doubleword.
- req_signed  input  1  loads only: sign-extend (LDURSW and signed sub-word); ignored for stores and size 3.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  64  store data, right-aligned (valid bits [8*2^size-1:0]).
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  qualifies resp_valid: misaligned or out of range.
- resp_rdata  output  64  load result, extended; 0 for stores and errors.
- mem_addr  output  ADDR_W  word index = {3'b0, latched_addr[ADDR_W-1:3]}.
- mem_wdata  output  64  write data to memory.
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable.
- mem_rdata  input  64  combinational read data from memory, valid in the same cycle as mem_read.

Behaviour:
- Byte order is little-endian. Lane k = bits [8k+7:8k] of the word; byte offset off = addr[2:0].
- On accept, latch addr, size, write, signed, wdata.
  - Misaligned when off mod 2^size != 0.
  - Out of range when the word index >= MEM_WORDS.
- States: IDLE, LOAD, MERGE, WRITE, RESP, ERR. All outputs are Moore-decoded from state and latched registers. There is no combinational path from req_* to mem_*.
- IDLE: req_ready=1, mem_read=0, mem_write=0. On accept, go to:
  - ERR if misaligned or out of range;
  - LOAD for a load;
  - WRITE for a size-3 store;
  - MERGE for a size 0–2 store.
- LOAD: mem_read=1. Capture the extracted lanes of mem_rdata into resp_rdata_q, extended per size/signed, then go to RESP.
- MERGE: mem_read=1. Capture mem_rdata with the 2^size bytes starting at lane off replaced by req_wdata's low bytes into merge_q, then go to WRITE.
- WRITE: mem_write=1. mem_wdata = req_wdata for size 3, else merge_q. Go to RESP. The memory commits on the rising edge that ends WRITE.
- RESP: resp_valid=1, resp_err=0. resp_rdata = resp_rdata_q for loads, 0 for stores. Go to IDLE.
- ERR: resp_valid=1, resp_err=1, resp_rdata=0, no mem_read/mem_write. Go to IDLE.
- Latency, counted from the accept edge at cycle T (resp_valid high in the listed cycle):
  - error: T+1;
  - load and full store: T+2;
  - sub-word store: T+3.
- Next accept is possible in the cycle after RESP/ERR.
- mem_addr and mem_wdata hold the latched values outside active states. mem_wdata = 0 except in WRITE.
- Reset (low) at any time, asynchronously:
  - state=IDLE;
  - mem_read=0, mem_write=0, resp_valid=0, resp_err=0;
  - resp_rdata=0, mem_addr=0, mem_wdata=0;
  - all latches cleared.
- Reset asserted during WRITE deasserts mem_write before the next edge, so no write occurs. A request present while reset is low is dropped.
- req_* inputs outside the accept cycle are don't-care. Changing them mid-transaction has no effect.
- The sub-word store lane masks never touch bytes outside [off, off+2^size-1].

Test Plan:
- Full store then load: STUR addr=0x10, wdata=0x1122334455667788 → mem_write high at T+1 with mem_addr=2; LDUR 0x10 → resp_rdata=0x1122334455667788 at T+2, resp_err=0.
- Sub-word merge: memory word 2 holds 0x1122334455667788; STURB addr=0x13, wdata=0xAB → MERGE reads, WRITE mem_wdata=0x11223344AB667788, resp at T+3.
- Extension: word 2 = 0x00000000F0008081. LDURB 0x10 signed → 0xFFFFFFFFFFFFFF81. Unsigned → 0x81. LDURSW 0x10 → 0xFFFFFFFFF0008081. LDURH 0x12 unsigned → 0xF000.
- Errors: LDURH addr=0x11 → resp_err=1 at T+1, no mem_read. STUR addr=128*8=0x400 → resp_err=1, no mem_write.
- Reset mid-write: assert reset low during WRITE of STUR addr=0x18 → mem_write drops immediately, word 3 unchanged, outputs at reset values, req_ready=1 after release.
- Back-to-back: req_valid held high with 3 loads → accepts spaced 3 cycles apart, req_ready low in LOAD/RESP, responses in order.
